fetch_sequencer: RTL and testbench

Fetch-side controller for the single-cycle CPU's instruction memory. Owns the program counter and drives the memory read address. Registers each fetched word with its PC for decode and resolves direct jumps at fetch. Also provides a program-load mode that sequences a loader's words into instruction memory from word 0 while fetch is held off.

---
 rtl/fetch_sequencer_if.sv | 49 ++++
 rtl/fetch_sequencer.sv | 126 ++++++++++++
 tb/tb_fetch_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_if
//  Description : Bus bundle between the fetch sequencer and its surroundings:
//                program loader, execute-stage redirect, instruction memory
//                and the decode-facing instruction register.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if;
    // Program loader
    logic        load_en;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    // Pipeline control
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    // Instruction memory
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    // Fetched instruction towards decode
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic        inst_valid;

    // Sequencer side
    modport master (
        input  load_en, load_valid, load_data,
        input  stall, redirect_valid, redirect_pc,
        input  mem_rdata,
        output load_ready,
        output mem_addr, mem_we, mem_wdata,
        output inst, pc_out, inst_valid
    );

    // System side (loader, execute stage, memory, decode)
    modport slave (
        output load_en, load_valid, load_data,
        output stall, redirect_valid, redirect_pc,
        output mem_rdata,
        input  load_ready,
        input  mem_addr, mem_we, mem_wdata,
        input  inst, pc_out, inst_valid
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Fetch-side controller for the single-cycle CPU. Owns the PC,
//                drives the instruction memory address, registers each
//                fetched word with its PC, resolves direct jumps at fetch and
//                sequences loader words into memory in program-load mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int          DEPTH    = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic          clk,
    input  wire logic          reset,   // synchronous, active-low
    fetch_sequencer_if.master  bus
);

    // Load pointer must be able to hold DEPTH itself (the "memory full" value)
    localparam int               PTR_W          = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] c_depth        = PTR_W'(DEPTH);
    localparam logic [5:0]       c_op_j         = 6'b000010;
    // The PC is word aligned at all times, including straight out of reset
    localparam logic [31:0]      c_reset_pc     = {RESET_PC[31:2], 2'b00};

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_LOAD  = 1'b1
    } state_t;

    state_t            r_state;
    logic [31:0]       r_pc;
    logic [31:0]       r_inst;
    logic [31:0]       r_pc_out;
    logic              r_inst_valid;
    logic [PTR_W-1:0]  r_load_ptr;

    logic              w_in_load;
    logic              w_load_ready;
    logic              w_load_fire;
    logic [31:0]       w_load_addr;
    logic [31:0]       w_redirect_pc;
    logic              w_is_jump;
    logic [31:0]       w_jump_pc;
    logic [31:0]       w_seq_pc;
    logic [31:0]       w_fetch_next_pc;

    assign w_in_load     = (r_state == S_LOAD);

    // Loader handshake: only while loading, still requested and not yet full
    assign w_load_ready  = w_in_load && bus.load_en && (r_load_ptr < c_depth);
    assign w_load_fire   = w_load_ready && bus.load_valid;
    assign w_load_addr   = 32'({r_load_ptr, 2'b00});

    // Redirect targets are forced onto a word boundary
    assign w_redirect_pc = bus.redirect_pc & ~32'h0000_0003;

    // Direct jump decode on the word being fetched this cycle; the target
    // keeps the upper nibble of the current PC
    assign w_is_jump     = (bus.mem_rdata[31:26] == c_op_j);
    assign w_jump_pc     = {r_pc[31:28], bus.mem_rdata[25:0], 2'b00};
    assign w_seq_pc      = r_pc + 32'd4;
    assign w_fetch_next_pc = w_is_jump ? w_jump_pc : w_seq_pc;

    // Memory-side outputs are combinational so the read returns this cycle
    assign bus.mem_addr   = w_in_load ? w_load_addr : r_pc;
    assign bus.mem_we     = w_load_fire;
    assign bus.mem_wdata  = bus.load_data;
    assign bus.load_ready = w_load_ready;

    assign bus.inst       = r_inst;
    assign bus.pc_out     = r_pc_out;
    assign bus.inst_valid = r_inst_valid;

    // Fetch/load state machine with PC, load pointer and instruction register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc         <= c_reset_pc;
            r_inst       <= 32'd0;
            r_pc_out     <= 32'd0;
            r_inst_valid <= 1'b0;
            r_load_ptr   <= '0;
            r_state      <= bus.load_en ? S_LOAD : S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.load_en) begin
                        // Enter program-load mode; PC is left untouched
                        r_state      <= S_LOAD;
                        r_load_ptr   <= '0;
                        r_inst_valid <= 1'b0;
                    end else if (bus.redirect_valid) begin
                        // Squash the word in flight; redirect beats stall
                        r_pc         <= w_redirect_pc;
                        r_inst_valid <= 1'b0;
                    end else if (bus.stall) begin
                        // Hold everything for the downstream stage
                        r_pc         <= r_pc;
                    end else begin
                        r_inst       <= bus.mem_rdata;
                        r_pc_out     <= r_pc;
                        r_inst_valid <= 1'b1;
                        r_pc         <= w_fetch_next_pc;
                    end
                end
                S_LOAD: begin
                    // Nothing is presented to decode while memory is rewritten
                    r_inst_valid <= 1'b0;
                    if (!bus.load_en) begin
                        r_state    <= S_FETCH;
                        r_pc       <= c_reset_pc;
                        r_load_ptr <= '0;
                    end else if (w_load_fire) begin
                        r_load_ptr <= r_load_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_FETCH;
                    r_inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed self-checking bench for fetch_sequencer with a
//                16-word instruction memory model and a write log.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .DEPTH    (16),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction memory model: combinational read, write on clock edge
    logic [31:0] imem [0:15];
    assign bus.mem_rdata = imem[bus.mem_addr[5:2]];

    int          n_checks = 0;
    int          n_errors = 0;
    int          wr_cnt   = 0;
    logic [31:0] wr_addr [0:31];
    logic [31:0] wr_data [0:31];
    logic [31:0] wr_max   = 32'd0;

    // Commit memory writes and log each one
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            imem[bus.mem_addr[5:2]] = bus.mem_wdata;
            if (wr_cnt < 32) begin
                wr_addr[wr_cnt] = bus.mem_addr;
                wr_data[wr_cnt] = bus.mem_wdata;
            end
            if (bus.mem_addr > wr_max) wr_max = bus.mem_addr;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int base;
    int k;
    logic [5:0] vpat;

    initial begin
        reset              = 1'b0;
        bus.load_en        = 1'b0;
        bus.load_valid     = 1'b0;
        bus.load_data      = 32'd0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        for (int i = 0; i < 16; i++) imem[i] = 32'h1000_0000 + i;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_pc_out", bus.pc_out, 32'd0);
        chk("rst_ready", {31'd0, bus.load_ready}, 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);

        // ---------------- 1: sequential fetch ----------------
        reset = 1'b1;
        #1;
        chk("seq_we_fetch", {31'd0, bus.mem_we}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("seq_valid", {31'd0, bus.inst_valid}, 32'd1);
            chk("seq_pc_out", bus.pc_out, 32'(4 * i));
            chk("seq_inst", bus.inst, 32'h1000_0000 + 32'(i));
        end

        // ---------------- 2: jump without bubble ----------------
        imem[0] = 32'h0800_0004;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0000;
        tick();
        chk("j_squash", {31'd0, bus.inst_valid}, 32'd0);
        bus.redirect_valid = 1'b0;
        tick();
        chk("j_valid0", {31'd0, bus.inst_valid}, 32'd1);
        chk("j_pc0", bus.pc_out, 32'h0);
        chk("j_inst0", bus.inst, 32'h0800_0004);
        tick();
        chk("j_valid1", {31'd0, bus.inst_valid}, 32'd1);
        chk("j_pc1", bus.pc_out, 32'h10);
        chk("j_inst1", bus.inst, 32'h1000_0004);
        tick();
        chk("j_pc2", bus.pc_out, 32'h14);

        // ---------------- 3: stall, then redirect under stall ----------------
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_pc", bus.pc_out, 32'h14);
            chk("stl_inst", bus.inst, 32'h1000_0005);
            chk("stl_valid", {31'd0, bus.inst_valid}, 32'd1);
        end
        bus.stall = 1'b0;
        tick();
        chk("stl_resume", bus.pc_out, 32'h18);
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0023;
        tick();
        chk("rd_squash", {31'd0, bus.inst_valid}, 32'd0);
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        tick();
        chk("rd_pc", bus.pc_out, 32'h20);
        chk("rd_inst", bus.inst, 32'h1000_0008);
        chk("rd_valid", {31'd0, bus.inst_valid}, 32'd1);

        // ---------------- 4: load 5 words with a gap ----------------
        bus.load_en = 1'b1;
        #1;
        chk("ld_ready_fetch", {31'd0, bus.load_ready}, 32'd0);
        tick();
        chk("ld_valid_off", {31'd0, bus.inst_valid}, 32'd0);
        chk("ld_ready", {31'd0, bus.load_ready}, 32'd1);
        base = wr_cnt;
        vpat = 6'b111011;   // bit j = load_valid in cycle j; bit 2 is the gap
        k    = 0;
        for (int j = 0; j < 6; j++) begin
            bus.load_valid = vpat[j];
            bus.load_data  = 32'hA000_0000 + 32'(k);
            #1;
            chk("ld_we", {31'd0, bus.mem_we}, {31'd0, vpat[j]});
            chk("ld_addr", bus.mem_addr, 32'(4 * k));
            tick();
            if (vpat[j]) k = k + 1;
        end
        chk("ld_count", 32'(wr_cnt - base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("ld_log_addr", wr_addr[base + i], 32'(4 * i));
            chk("ld_log_data", wr_data[base + i], 32'hA000_0000 + 32'(i));
        end
        bus.load_en    = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hDEAD_BEEF;
        #1;
        chk("ld_exit_ready", {31'd0, bus.load_ready}, 32'd0);
        chk("ld_exit_we", {31'd0, bus.mem_we}, 32'd0);
        tick();
        bus.load_valid = 1'b0;
        chk("ld_exit_addr", bus.mem_addr, 32'h0);
        tick();
        chk("ld_fetch_valid", {31'd0, bus.inst_valid}, 32'd1);
        chk("ld_fetch_pc", bus.pc_out, 32'h0);
        chk("ld_fetch_inst", bus.inst, 32'hA000_0000);
        chk("ld_count_after", 32'(wr_cnt - base), 32'd5);

        // ---------------- 5: overfill ----------------
        bus.load_en = 1'b1;
        tick();
        base = wr_cnt;
        for (int i = 0; i < 20; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 32'hB000_0000 + 32'(i);
            #1;
            chk("full_ready", {31'd0, bus.load_ready}, (i < 16) ? 32'd1 : 32'd0);
            tick();
        end
        chk("full_count", 32'(wr_cnt - base), 32'd16);
        chk("full_last_addr", wr_addr[base + 15], 32'd60);
        chk("full_max_addr", wr_max, 32'd60);

        // ---------------- 6: reset mid-load, PC wrap ----------------
        bus.load_en    = 1'b0;
        bus.load_valid = 1'b0;
        tick();
        bus.load_en = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 32'hC000_0000 + 32'(i);
            tick();
        end
        chk("mid_addr", bus.mem_addr, 32'd28);
        reset = 1'b0;
        tick();
        reset          = 1'b1;
        bus.load_valid = 1'b0;
        #1;
        chk("mid_rst_addr", bus.mem_addr, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.load_ready}, 32'd1);
        chk("mid_rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("mid_rst_inst", bus.inst, 32'd0);
        tick();
        chk("mid_hold_addr", bus.mem_addr, 32'd0);
        bus.load_en = 1'b0;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        chk("wrap_addr", bus.mem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc_hi", bus.pc_out, 32'hFFFF_FFFC);
        chk("wrap_inst_hi", bus.inst, 32'hB000_000F);
        tick();
        chk("wrap_pc_lo", bus.pc_out, 32'h0);
        chk("wrap_inst_lo", bus.inst, 32'hC000_0000);
        chk("wrap_valid", {31'd0, bus.inst_valid}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
